store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 150 +++++++++++++++
 tb/tb_store_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-store write buffer between the MIPS core data port and a handshaked memory.
// Loads forward from the youngest buffered store and stall the core only on a miss.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic                   memread,
  input  logic [AW-1:0]          adr,
  input  logic [DW-1:0]          writedata,
  output logic [DW-1:0]          readdata,
  output logic                   stall,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_adr,
  output logic [DW-1:0]          mem_wd,
  input  logic                   mem_ack,
  input  logic [DW-1:0]          mem_rd,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = AW - 2;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tag [DEPTH];
  logic [DW-1:0]   r_dat [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_enq;
  logic            w_pop;
  logic            w_rd_done;
  logic            w_hit;
  logic            w_miss;
  logic [DW-1:0]   w_fwd;
  logic [PW-1:0]   w_idx;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_enq     = memwrite & ~w_full;
  assign w_pop     = (r_state == WR) & mem_ack;
  assign w_rd_done = (r_state == RD) & mem_ack;
  assign w_miss    = memread & ~w_hit;
  assign count     = r_count;

  // Search oldest to youngest so the last match (youngest store) wins; the in-flight head stays valid.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + i[PW-1:0];
      if ((CW'(i) < r_count) && (r_tag[w_idx] == adr[AW-1:2])) begin
        w_hit = 1'b1;
        w_fwd = r_dat[w_idx];
      end else begin
        w_hit = w_hit;
      end
    end
  end

  // Core-facing load data and stall.
  always_comb begin
    stall = (memwrite & w_full) | (w_miss & ~w_rd_done);
    if (memread & w_hit) begin
      readdata = w_fwd;
    end else if (w_rd_done) begin
      readdata = mem_rd;
    end else begin
      readdata = '0;
    end
  end

  // FIFO storage written at the tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
        r_dat[i] <= '0;
      end
    end else if (w_enq) begin
      r_tag[r_tail] <= adr[AW-1:2];
      r_dat[r_tail] <= writedata;
    end
  end

  // Head/tail pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Memory request FSM: a load miss takes priority over draining; requests hold until ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_adr <= '0;
      mem_wd  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state <= RD;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            mem_adr <= {adr[AW-1:2], 2'b00};
          end else if (r_count != '0) begin
            r_state <= WR;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            mem_adr <= {r_tag[r_head], 2'b00};
            mem_wd  <= r_dat[r_head];
          end
        end
        WR, RD: begin
          if (mem_ack) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: per-cycle vector table plus hand sequences,
// with a queue of expected memory writes checked as the memory accepts them.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite, memread, mem_ack;
  logic [31:0] adr, writedata, mem_rd;
  logic [31:0] readdata, mem_adr, mem_wd;
  logic        stall, mem_req, mem_we;
  logic [2:0]  count;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
    .adr(adr), .writedata(writedata), .readdata(readdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mw;
    bit          mr;
    logic [31:0] a;
    logic [31:0] wd;
    bit          ack;
    logic [31:0] rdata;
    bit          st;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  vec_t vecs[$];
  wr_t  wq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(bit mw, bit mr, logic [31:0] a, logic [31:0] wd, bit ack,
                     logic [31:0] rdata, bit st, int cnt);
    vecs.push_back('{mw, mr, a, wd, ack, rdata, st, cnt});
  endtask

  task automatic exp_write(logic [31:0] a, logic [31:0] d);
    wq.push_back('{a, d});
  endtask

  // Drive one cycle at the falling edge, then observe memory-side writes just before the rising edge.
  task automatic step(bit mw, bit mr, logic [31:0] a, logic [31:0] wd, bit ack, logic [31:0] rd);
    wr_t e;
    @(negedge clk);
    memwrite = mw; memread = mr; adr = a; writedata = wd; mem_ack = ack; mem_rd = rd;
    #4;
    if (mem_req && mem_we && mem_ack) begin
      if (wq.size() == 0) begin
        chk("spurious_write", {31'd0, mem_we}, 32'd0);
      end else begin
        e = wq.pop_front();
        chk("wr_adr", mem_adr, e.a);
        chk("wr_data", mem_wd, e.d);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    memwrite = 1'b0; memread = 1'b0; mem_ack = 1'b0;
    adr = '0; writedata = '0; mem_rd = '0;

    // Test 1: three posted stores then in-order drain
    add(1, 0, 32'h10, 32'd5, 0, 32'd0, 0, 0);
    add(1, 0, 32'h14, 32'd6, 0, 32'd0, 0, 1);
    add(1, 0, 32'h18, 32'd7, 0, 32'd0, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 3);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 1);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 1);
    add(0, 0, 32'h0, 32'd0, 0, 32'd0, 0, 0);
    // Test 2: youngest same-address store forwards
    add(1, 0, 32'h20, 32'hAAAA, 0, 32'd0, 0, 0);
    add(1, 0, 32'h20, 32'hBBBB, 0, 32'd0, 0, 1);
    add(0, 1, 32'h20, 32'd0, 0, 32'hBBBB, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 1);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 1);
    add(0, 0, 32'h0, 32'd0, 0, 32'd0, 0, 0);
    // Test 4: fill, stall on full even while the head pops, then drain
    add(1, 0, 32'h100, 32'd1, 0, 32'd0, 0, 0);
    add(1, 0, 32'h104, 32'd2, 0, 32'd0, 0, 1);
    add(1, 0, 32'h108, 32'd3, 0, 32'd0, 0, 2);
    add(1, 0, 32'h10C, 32'd4, 0, 32'd0, 0, 3);
    add(1, 0, 32'h110, 32'd5, 0, 32'd0, 1, 4);
    add(1, 0, 32'h110, 32'd5, 1, 32'd0, 1, 4);
    add(1, 0, 32'h110, 32'd5, 0, 32'd0, 0, 3);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 4);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 3);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 3);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 2);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 1);
    add(0, 0, 32'h0, 32'd0, 1, 32'd0, 0, 1);
    add(0, 0, 32'h0, 32'd0, 0, 32'd0, 0, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #4;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_adr", mem_adr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].mw && !vecs[i].st) exp_write(vecs[i].a, vecs[i].wd);
      step(vecs[i].mw, vecs[i].mr, vecs[i].a, vecs[i].wd, vecs[i].ack, 32'd0);
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].st});
      chk($sformatf("v%0d_readdata", i), readdata, vecs[i].rdata);
      chk($sformatf("v%0d_count", i), {29'd0, count}, vecs[i].cnt);
    end

    // Test 3: load miss on empty buffer, ack two cycles after mem_req
    step(0, 1, 32'h40, 0, 0, 0);
    chk("t3_detect_stall", {31'd0, stall}, 32'd1);
    chk("t3_detect_req", {31'd0, mem_req}, 32'd0);
    step(0, 1, 32'h40, 0, 0, 0);
    chk("t3_req", {31'd0, mem_req}, 32'd1);
    chk("t3_we", {31'd0, mem_we}, 32'd0);
    chk("t3_adr", mem_adr, 32'h40);
    chk("t3_wait_stall", {31'd0, stall}, 32'd1);
    step(0, 1, 32'h40, 0, 0, 0);
    chk("t3_wait2_stall", {31'd0, stall}, 32'd1);
    step(0, 1, 32'h40, 0, 1, 32'h1234);
    chk("t3_ack_stall", {31'd0, stall}, 32'd0);
    chk("t3_ack_readdata", readdata, 32'h1234);
    step(0, 0, 0, 0, 0, 0);
    chk("t3_done_req", {31'd0, mem_req}, 32'd0);

    // Test 5: load miss behind an in-flight write
    exp_write(32'h10, 32'd9);
    step(1, 0, 32'h10, 32'd9, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h80, 0, 0, 0);
    chk("t5_wr_inflight", {31'd0, mem_we}, 32'd1);
    chk("t5_miss_stall", {31'd0, stall}, 32'd1);
    step(0, 1, 32'h80, 0, 1, 0);
    chk("t5_wr_ack_stall", {31'd0, stall}, 32'd1);
    step(0, 1, 32'h80, 0, 0, 0);
    chk("t5_idle_gap_req", {31'd0, mem_req}, 32'd0);
    chk("t5_idle_gap_stall", {31'd0, stall}, 32'd1);
    step(0, 1, 32'h80, 0, 0, 0);
    chk("t5_rd_req", {31'd0, mem_req}, 32'd1);
    chk("t5_rd_we", {31'd0, mem_we}, 32'd0);
    chk("t5_rd_adr", mem_adr, 32'h80);
    step(0, 1, 32'h80, 0, 1, 32'hCAFE);
    chk("t5_rd_readdata", readdata, 32'hCAFE);
    chk("t5_rd_stall", {31'd0, stall}, 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // Test 6: asynchronous reset while reading with two stores queued
    exp_write(32'h200, 32'd1);
    step(1, 0, 32'h200, 32'd1, 0, 0);
    step(1, 0, 32'h204, 32'd2, 0, 0);
    step(1, 0, 32'h208, 32'd3, 0, 0);
    step(0, 1, 32'h300, 0, 1, 0);
    step(0, 1, 32'h300, 0, 0, 0);
    step(0, 1, 32'h300, 0, 0, 0);
    chk("t6_pre_req", {31'd0, mem_req}, 32'd1);
    chk("t6_pre_count", {29'd0, count}, 32'd2);
    #3;
    memread = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_async_req", {31'd0, mem_req}, 32'd0);
    chk("t6_async_count", {29'd0, count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 1, 0);
      chk($sformatf("t6_post_req%0d", i), {31'd0, mem_req}, 32'd0);
    end

    chk("writes_outstanding", wq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
